// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 keyboard Wishbone slave.
// Holds register offsets, STATUS bit positions and the receiver state encoding.
// Imported by ps2_rx_frame and ps2_keyboard_wb.
package ps2_kbd_pkg;

    // Byte offsets of the two CPU-visible registers
    localparam logic [31:0] DATA_OFS   = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

    // STATUS register bit positions
    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_PERR      = 3;
    localparam int ST_FERR      = 4;
    localparam int ST_COUNT_LSB = 8;

    // Receiver frame state
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: sync, falling-edge detect, framing/parity check, timeout.
// Latency: byte_vld pulses 3 clk after the stop-bit falling edge reaches the pin (2 sync + 1 reg).
// No backpressure: byte_vld/perr_pulse/ferr_pulse are single-cycle pulses the consumer must take.
// Ports: clk, rst_n (async active-low), ps2_clk/ps2_data (raw pins),
//        byte_dat[7:0] (received byte), byte_vld, perr_pulse, ferr_pulse.
module ps2_rx_frame
    import ps2_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_dat,
    output logic       byte_vld,
    output logic       perr_pulse,
    output logic       ferr_pulse
);

    localparam int             TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic [1:0]      clk_sync_q,  clk_sync_d;
    logic [1:0]      data_sync_q, data_sync_d;
    logic            clk_prev_q,  clk_prev_d;
    rx_state_e       state_q,     state_d;
    logic [2:0]      bit_cnt_q,   bit_cnt_d;
    logic [7:0]      shift_q,     shift_d;
    logic            par_q,       par_d;
    logic [TO_W-1:0] to_cnt_q,    to_cnt_d;
    logic [7:0]      byte_q,      byte_d;
    logic            byte_vld_q,  byte_vld_d;
    logic            perr_q,      perr_d;
    logic            ferr_q,      ferr_d;

    logic fall;
    logic rx_bit;

    always_comb begin
        // Stage 0 captures the raw pin, stage 1 is the usable synchronized value
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        clk_prev_d  = clk_sync_q[1];

        fall   = clk_prev_q & ~clk_sync_q[1];
        rx_bit = data_sync_q[1];

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        to_cnt_d   = to_cnt_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;

        if (fall) begin
            to_cnt_d = '0;
            case (state_q)
                RX_IDLE: begin
                    // A high "start bit" is treated as line noise
                    if (!rx_bit) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                RX_DATA: begin
                    shift_d = {rx_bit, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                RX_PARITY: begin
                    par_d   = rx_bit;
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    state_d = RX_IDLE;
                    if (!rx_bit) begin
                        ferr_d = 1'b1;
                    end else if (^{shift_q, par_q}) begin
                        byte_d     = shift_q;
                        byte_vld_d = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end else if (state_q != RX_IDLE) begin
            // Device stopped clocking mid-frame: abandon the partial byte
            if (to_cnt_q == TO_MAX) begin
                state_d  = RX_IDLE;
                ferr_d   = 1'b1;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            state_q     <= RX_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            byte_q      <= 8'h00;
            byte_vld_q  <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            byte_q      <= byte_d;
            byte_vld_q  <= byte_vld_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end

    assign byte_dat   = byte_q;
    assign byte_vld   = byte_vld_q;
    assign perr_pulse = perr_q;
    assign ferr_pulse = ferr_q;

endmodule

// File: rtl/ps2_keyboard_wb.sv
// Wishbone keyboard slave: PS/2 receiver feeding a scan-code FIFO, DATA/STATUS registers, level irq.
// Latency: every access ACKs one cycle after STB is sampled; DAT_O is valid only in the ACK cycle.
// Backpressure: none toward PS/2 -- a byte arriving at a full FIFO (without a same-cycle pop) is dropped and sets OVF.
// Ports: clk, reset (async active-low), STB/WE/ADDR/DAT_I in, DAT_O/ACK out,
//        ps2_clk/ps2_data raw pins, irq high while the FIFO holds scan codes.
module ps2_keyboard_wb
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        STB,
    input  logic        WE,
    input  logic [31:0] ADDR,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic        irq
);

    localparam int              PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Receiver
    logic [7:0] rx_byte_dat;
    logic       rx_byte_vld;
    logic       rx_perr;
    logic       rx_ferr;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .rst_n      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_dat   (rx_byte_dat),
        .byte_vld   (rx_byte_vld),
        .perr_pulse (rx_perr),
        .ferr_pulse (rx_ferr)
    );

    // State
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic             ovf_q,      ovf_d;
    logic             perr_q,     perr_d;
    logic             ferr_q,     ferr_d;
    logic             irq_q,      irq_d;
    logic             ack_q,      ack_d;
    logic [31:0]      dat_q,      dat_d;
    logic             pop_pend_q, pop_pend_d;  // DATA read of a non-empty FIFO: pop in the ACK cycle
    logic [2:0]       w1c_q,      w1c_d;       // {FERR, PERR, OVF} clear mask, applied in the ACK cycle

    logic        fifo_empty;
    logic        fifo_full;
    logic        access;
    logic        sel_status;
    logic        push_ok;
    logic        ovf_set;
    logic [31:0] status_word;

    // Only ADDR[2] and DAT_I[4:2] are decoded
    logic unused_bus;
    assign unused_bus = ^{ADDR[31:3], ADDR[1:0], DAT_I[31:5], DAT_I[1:0]};

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DEPTH_C);
        access     = STB & ~ack_q;
        sel_status = (ADDR[2] == STATUS_OFS[2]);

        status_word                           = 32'h0;
        status_word[ST_COUNT_LSB +: 8]        = 8'(count_q);
        status_word[ST_FERR]                  = ferr_q;
        status_word[ST_PERR]                  = perr_q;
        status_word[ST_OVF]                   = ovf_q;
        status_word[ST_FULL]                  = fifo_full;
        status_word[ST_EMPTY]                 = fifo_empty;

        // Bus side: capture the response and any side effect for the ACK cycle
        ack_d      = access;
        dat_d      = 32'h0;
        pop_pend_d = 1'b0;
        w1c_d      = 3'b000;
        if (access) begin
            if (!WE) begin
                if (sel_status) begin
                    dat_d = status_word;
                end else if (!fifo_empty) begin
                    dat_d      = {1'b1, 23'h0, mem_q[rd_ptr_q]};
                    pop_pend_d = 1'b1;
                end
            end else if (sel_status) begin
                w1c_d = DAT_I[ST_FERR:ST_OVF];
            end
        end

        // A pending pop frees a slot in the same cycle, so a simultaneous push is accepted
        push_ok = rx_byte_vld & (~fifo_full | pop_pend_q);
        ovf_set = rx_byte_vld & fifo_full & ~pop_pend_q;

        wr_ptr_d = push_ok    ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_pend_q ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        if (push_ok && !pop_pend_q) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop_pend_q) begin
            count_d = count_q - CNT_W'(1);
        end

        // Set has priority over a same-cycle W1C
        ovf_d  = ovf_set | (ovf_q  & ~w1c_q[0]);
        perr_d = rx_perr | (perr_q & ~w1c_q[1]);
        ferr_d = rx_ferr | (ferr_q & ~w1c_q[2]);

        irq_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            irq_q      <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= 32'h0;
            pop_pend_q <= 1'b0;
            w1c_q      <= 3'b000;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            irq_q      <= irq_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            pop_pend_q <= pop_pend_d;
            w1c_q      <= w1c_d;
        end
    end

    // Storage needs no reset: entries are only read below the count
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= rx_byte_dat;
        end
    end

    assign ACK   = ack_q;
    assign DAT_O = dat_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_ps2_keyboard_wb.sv
module tb_ps2_keyboard_wb;

    localparam int TO   = 200;
    localparam int HALF = 20;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        STB      = 1'b0;
    logic        WE       = 1'b0;
    logic [31:0] ADDR     = 32'h0;
    logic [31:0] DAT_I    = 32'h0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [31:0] DAT_O;
    logic        ACK;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_q  [$];
    string       name_q [$];
    bit          chk_q  [$];

    ps2_keyboard_wb #(
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .STB      (STB),
        .WE       (WE),
        .ADDR     (ADDR),
        .DAT_I    (DAT_I),
        .DAT_O    (DAT_O),
        .ACK      (ACK),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every ACK
    always @(negedge clk) begin
        if (reset === 1'b1 && ACK === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_ack: got DAT_O 0x%08h expected no transfer", DAT_O);
            end else begin
                logic [31:0] e;
                string       nm;
                bit          c;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                c  = chk_q.pop_front();
                if (c) check(nm, DAT_O, e);
            end
        end
    end

    // Caller is aligned to posedge+1; returns aligned to posedge+1
    task automatic wb_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdat,
                           input logic [31:0] expv, input string nm);
        bit got;
        exp_q.push_back(expv);
        name_q.push_back(nm);
        chk_q.push_back(!we);
        STB   = 1'b1;
        WE    = we;
        ADDR  = addr;
        DAT_I = wdat;
        got   = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ACK === 1'b1) got = 1'b1;
        end
        STB = 1'b0;
        WE  = 1'b0;
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_ack_timeout: got no ACK expected ACK within 20 cycles", nm);
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
            void'(chk_q.pop_back());
        end
    endtask

    task automatic rd_data(input logic [31:0] e, input string nm);
        wb_xfer(1'b0, 32'h0, 32'h0, e, nm);
    endtask

    task automatic rd_stat(input logic [31:0] e, input string nm);
        wb_xfer(1'b0, 32'h4, 32'h0, e, nm);
    endtask

    task automatic wr_stat(input logic [31:0] v);
        wb_xfer(1'b1, 32'h4, v, 32'h0, "wr_status");
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit: data set while clock high, falling edge at posedge+1
    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        #1;
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1;
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ bad_par);
        ps2_bit(1'b1);
        idle(HALF);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        idle(4);
        check("rst_ack", {31'h0, ACK}, 32'h0);
        check("rst_dat", DAT_O, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        reset = 1'b1;
        idle(3);
        rd_stat(32'h0000_0001, "rst_status");
        rd_data(32'h0000_0000, "empty_data");

        // Good frame 0x1C
        send_frame(8'h1C, 1'b0);
        check("t1_irq", {31'h0, irq}, 32'h1);
        rd_stat(32'h0000_0100, "t1_status1");
        wb_xfer(1'b1, 32'h0, 32'hFFFF_FFFF, 32'h0, "wr_data");
        rd_stat(32'h0000_0100, "t1_status_after_wr");
        rd_data(32'h8000_001C, "t1_data");
        rd_stat(32'h0000_0001, "t1_status2");
        idle(2);
        check("t1_irq_clr", {31'h0, irq}, 32'h0);

        // Bad parity
        send_frame(8'h1C, 1'b1);
        rd_stat(32'h0000_0009, "t2_perr");
        wr_stat(32'h0000_0008);
        rd_stat(32'h0000_0001, "t2_perr_clr");

        // Overflow
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
        check("t3_irq", {31'h0, irq}, 32'h1);
        rd_stat(32'h0000_0806, "t3_ovf");
        for (int i = 1; i <= 8; i++) rd_data(32'h8000_0000 | 32'(i), "t3_data");
        rd_data(32'h0000_0000, "t3_empty");
        wr_stat(32'h0000_001C);
        rd_stat(32'h0000_0001, "t3_clr");

        // Timeout on a partial frame
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        idle(TO + 50);
        rd_stat(32'h0000_0011, "t4_ferr");
        send_frame(8'hF0, 1'b0);
        rd_data(32'h8000_00F0, "t4_data");
        wr_stat(32'h0000_0010);
        rd_stat(32'h0000_0001, "t4_clr");

        // Pop and push in the same cycle on a full FIFO
        for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b0);
        rd_stat(32'h0000_0802, "t5_full");
        fork
            send_frame(8'h19, 1'b0);
            begin
                // Stop-bit edge reaches byte_vld 3 posedges later; land ACK on that cycle
                repeat (11) @(negedge ps2_clk);
                @(posedge clk);
                @(posedge clk);
                #1;
                rd_data(32'h8000_0011, "t5_head");
            end
        join
        rd_stat(32'h0000_0802, "t5_no_ovf");
        for (int i = 0; i < 8; i++) rd_data(32'h8000_0012 + 32'(i), "t5_drain");
        rd_stat(32'h0000_0001, "t5_empty");

        // Reset mid-frame with two bytes queued
        send_frame(8'h21, 1'b0);
        send_frame(8'h22, 1'b0);
        check("t6_irq_pre", {31'h0, irq}, 32'h1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        reset = 1'b0;
        #1;
        check("t6_ack", {31'h0, ACK}, 32'h0);
        check("t6_irq", {31'h0, irq}, 32'h0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        idle(5);
        reset = 1'b1;
        idle(3);
        rd_stat(32'h0000_0001, "t6_status");
        send_frame(8'hA5, 1'b0);
        rd_data(32'h8000_00A5, "t6_data");
        rd_stat(32'h0000_0001, "t6_status2");

        idle(5);
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
